cic_interpolator: RTL and testbench
===================================

// Module: cic_interpolator
// PURPOSE
//  N-stage CIC interpolator (differential delay 1), upsampling by integer R.
//  Transmit-side counterpart of the CIC decimator chain. Combs run at the
//  input rate, R-fold zero-stuffing follows, integrators run at the output rate.
//  Valid/ready elastic handshake on both sides; one output per cycle max.
// PARAMETERS
//  InputLengthBits   16  2's-complement input width
//  OutputLengthBits  22  2's-complement output width
//  Rate              4   interpolation factor R, 2..64
//  Order             3   number of comb stages and of integrator stages N, 1..6
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  reset, synchronous, active-high
//  in         in   InputLengthBits    input sample (signed)
//  in_valid   in   1                  input sample present
//  in_ready   out  1                  block accepts `in` this cycle
//  out        out  OutputLengthBits   output sample (signed)
//  out_valid  out  1                  `out` holds a new sample
//  out_ready  in   1                  downstream takes `out` this cycle
// BEHAVIOUR
//  - Internal width W = InputLengthBits + Order*clog2(Rate). All comb and
//    integrator arithmetic is mod 2^W (wrap-around). Wrap is intentional and
//    correct because the final gain Rate^(Order-1) fits in W.
//  - Reset clears all comb delay registers, integrators, zeros_left, out and
//    out_valid to 0. in_ready is 0 while rst is high. Reset mid-burst discards
//    pending zero-stuff samples.
//  - advance = !out_valid || out_ready. in_ready = !rst && zeros_left==0 && advance.
//  - Accept (in_valid && in_ready):
//    - Comb cascade c_k = c_{k-1} - d_k computes combinationally, with c_0 = sext(in).
//    - d_k <= c_{k-1}.
//    - Integrators step with x = c_N.
//    - zeros_left <= Rate-1.
//  - advance && zeros_left>0: integrators step with x=0; zeros_left--; no input accepted.
//  - advance && zeros_left==0 && !in_valid: out_valid <= 0; integrators hold.
//  - Integrator step: i_0' = i_0 + x; i_k' = i_k + i_{k-1}'. This is a direct
//    (non-pipelined) cascade. Then out <= scale(i_{N-1}') and out_valid <= 1.
//  - Latency: sample accepted at cycle t appears on out at t+1. Its R-1 zero
//    phases follow at one per advancing cycle.
//  - Throughput: with out_ready held high and in_valid high, out_valid stays
//    high continuously. in_ready pulses once every Rate cycles.
//  - Backpressure: out_valid && !out_ready freezes out, integrators, zeros_left
//    and combs. out is stable until taken.
//  - Scaling: if OutputLengthBits >= W, sign-extend. Otherwise drop the W-OutputLengthBits LSBs.
//  - DC gain is Rate^(Order-1). Example: a constant input of 3 with R=4, N=3
//    settles to 48.
//  - Elaboration $error if Rate<2, Order<1, Order>6, or OutputLengthBits < InputLengthBits.
// CONFIGURATION
//  - Macro CIC_INTERPOLATOR_ROUND_EN.
//  - Defined: when LSBs are dropped, add 2^(W-OutputLengthBits-1) before the
//    drop (round half up). The sum is computed in W+1 bits so no overflow
//    occurs; the result is saturated to OutputLengthBits.
//  - Undefined: plain truncation (floor), no saturation logic.
//  - No effect when OutputLengthBits >= W.
// STRUCTURE
//  - Package cic_pkg:
//    - function CicInterpWidth(in_bits, rate, order) returning W
//    - function CicGrowthBits(rate, order)
//    - localparam MaxRate=64, MaxOrder=6
//    - Shared with the decimator chain.
//  - Sub-module cic_comb_stage: one W-bit delay reg plus subtractor, with an
//    enable input. Instantiated Order times via generate. Integrators stay
//    inline because of the chained next-state sum.
// TESTING
//  1. R=4, N=1, out_ready=1: impulse in=1, then in=0 -> out 1,1,1,1,0,0,0,0.
//  2. R=2, N=2: impulse 1 then zeros -> out 1,2,1,0,0,0 (triangle).
//  3. R=4, N=3: constant in=3 for 8 inputs -> out settles at 48. Check
//     in_ready pattern 1,0,0,0 repeating.
//  4. Backpressure: deassert out_ready for 5 cycles mid-burst -> out held
//     constant, no input accepted, sequence resumes unchanged.
//  5. Assert rst during zero-stuff phase -> next cycle out=0, out_valid=0.
//     After release, in_ready=1 and impulse response restarts clean.
//  6. Max-negative input -2^15, R=4, N=3, full-width output -> -2^15*16
//     exact. With ROUND_EN and a 12-bit output, rounded values match the model.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC definitions: internal width helpers and the rate/order limits
// used by both the interpolator and the decimator chain.
package cic_pkg;

    localparam int MaxRate       = 64;
    localparam int MaxOrder      = 6;
    // Width of the zero-stuff phase counter (holds Rate-1 up to MaxRate-1).
    localparam int ZeroCountBits = $clog2(MaxRate);

    // Bit growth of an N-stage CIC with differential delay 1.
    function automatic int CicGrowthBits(input int rate, input int order);
        return order * $clog2(rate);
    endfunction

    // Internal datapath width of the interpolator.
    function automatic int CicInterpWidth(input int in_bits, input int rate, input int order);
        return in_bits + CicGrowthBits(rate, order);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section (differential delay 1): c_o = c_i - c_i(previous accept).
// The delay register only advances when en_i is high, so the comb runs at
// the input sample rate.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int Width = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [Width-1:0] c_i,
    output logic [Width-1:0] c_o
);

    logic [Width-1:0] d_q;
    logic [Width-1:0] d_d;

    // Next delay value and the modular difference.
    always_comb begin
        if (en_i) begin
            d_d = c_i;
        end else begin
            d_d = d_q;
        end
        c_o = c_i - d_q;
    end

    // Delay register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator, upsampling by Rate. Combs run at the input rate,
// the input is zero-stuffed R-fold, integrators run at the output rate.
// Valid/ready handshake on both sides; at most one output per cycle.
// Build option: define CIC_INTERPOLATOR_ROUND_EN to round half up (with
// saturation) instead of truncating when output LSBs are dropped.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int InputLengthBits  = 16,
    parameter int OutputLengthBits = 22,
    parameter int Rate             = 4,
    parameter int Order            = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [InputLengthBits-1:0]  in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [OutputLengthBits-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int W  = CicInterpWidth(InputLengthBits, Rate, Order);
    localparam int ZW = ZeroCountBits;
    localparam logic [ZW-1:0] ZerosReload = ZW'(Rate - 1);

    if (Rate < 2 || Rate > MaxRate) begin : g_bad_rate
        $error("cic_interpolator: Rate must be in 2..64");
    end
    if (Order < 1 || Order > MaxOrder) begin : g_bad_order
        $error("cic_interpolator: Order must be in 1..6");
    end
    if (OutputLengthBits < InputLengthBits) begin : g_bad_width
        $error("cic_interpolator: OutputLengthBits must be >= InputLengthBits");
    end

    logic [W-1:0]                comb_s      [0:Order];
    logic [W-1:0]                integ_q     [0:Order-1];
    logic [W-1:0]                integ_d     [0:Order-1];
    logic [W-1:0]                integ_sum_s [0:Order-1];
    logic [W-1:0]                x_s;
    logic [W-1:0]                integ_last_s;
    logic [ZW-1:0]               zeros_left_q;
    logic [ZW-1:0]               zeros_left_d;
    logic [OutputLengthBits-1:0] out_q;
    logic [OutputLengthBits-1:0] out_d;
    logic [OutputLengthBits-1:0] scaled_s;
    logic                        out_valid_q;
    logic                        out_valid_d;
    logic                        advance_s;
    logic                        accept_s;
    logic                        step_s;

    // The output register can take a new value when empty or being drained.
    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = !rst && (zeros_left_q == '0) && advance_s;
    assign accept_s  = in_valid && in_ready;
    // Integrators step on an accepted sample or on each stuffed zero phase.
    assign step_s    = accept_s || (advance_s && (zeros_left_q != '0));
    assign comb_s[0] = {{(W-InputLengthBits){in[InputLengthBits-1]}}, in};

    for (genvar k = 0; k < Order; k++) begin : g_comb
        cic_comb_stage #(
            .Width (W)
        ) u_comb (
            .clk  (clk),
            .rst  (rst),
            .en_i (accept_s),
            .c_i  (comb_s[k]),
            .c_o  (comb_s[k+1])
        );
    end

    // Direct integrator cascade: each stage adds the freshly updated previous stage.
    always_comb begin
        if (accept_s) begin
            x_s = comb_s[Order];
        end else begin
            x_s = '0;
        end
        integ_sum_s[0] = integ_q[0] + x_s;
        for (int k = 1; k < Order; k++) begin
            integ_sum_s[k] = integ_q[k] + integ_sum_s[k-1];
        end
    end

    assign integ_last_s = integ_sum_s[Order-1];

    if (OutputLengthBits >= W) begin : g_extend
        assign scaled_s = OutputLengthBits'($signed(integ_last_s));
    end else begin : g_drop
        localparam int Drop = W - OutputLengthBits;
`ifdef CIC_INTERPOLATOR_ROUND_EN
        localparam logic [W:0] Half = {{W{1'b0}}, 1'b1} << (Drop - 1);
        logic [W:0] round_sum_s;
        logic       unused_round_s;
        assign round_sum_s    = {integ_last_s[W-1], integ_last_s} + Half;
        assign unused_round_s = ^round_sum_s[Drop-1:0];
        // Round half up, then clamp if the rounded value left the output range.
        always_comb begin
            if (round_sum_s[W] == round_sum_s[W-1]) begin
                scaled_s = round_sum_s[W-1:Drop];
            end else if (round_sum_s[W]) begin
                scaled_s = {1'b1, {(OutputLengthBits-1){1'b0}}};
            end else begin
                scaled_s = {1'b0, {(OutputLengthBits-1){1'b1}}};
            end
        end
`else
        logic unused_lsb_s;
        assign scaled_s     = integ_last_s[W-1:Drop];
        assign unused_lsb_s = ^integ_last_s[Drop-1:0];
`endif
    end

    // Next state of integrators, zero-stuff counter and output register.
    always_comb begin
        zeros_left_d = zeros_left_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        for (int k = 0; k < Order; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (step_s) begin
            for (int k = 0; k < Order; k++) begin
                integ_d[k] = integ_sum_s[k];
            end
            out_d       = scaled_s;
            out_valid_d = 1'b1;
            if (accept_s) begin
                zeros_left_d = ZerosReload;
            end else begin
                zeros_left_d = zeros_left_q - ZW'(1);
            end
        end else if (advance_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset also drops any pending zero-stuff phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < Order; k++) begin
                integ_q[k] <= '0;
            end
            zeros_left_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            for (int k = 0; k < Order; k++) begin
                integ_q[k] <= integ_d[k];
            end
            zeros_left_q <= zeros_left_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator. Four instances with different
// Rate/Order/output widths are checked against a convolution model: the
// output stream is the zero-stuffed input convolved with the CIC impulse
// response (a length-R boxcar convolved with itself Order times), mod 2^W.
module tb_cic_interpolator;

    localparam int NI = 4;

    function automatic int rate_of(input int g);
        case (g)
            0:       return 4;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int order_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int olen_of(input int g);
        case (g)
            3:       return 12;
            default: return 22;
        endcase
    endfunction

    function automatic int width_of(input int g);
        return 16 + order_of(g) * $clog2(rate_of(g));
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   din  [NI];
    logic [21:0]   dout [NI];
    logic [NI-1:0] vin;
    logic [NI-1:0] rin;
    logic [NI-1:0] vout;
    logic [NI-1:0] ordy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int R  = rate_of(g);
        localparam int N  = order_of(g);
        localparam int OL = olen_of(g);
        logic [OL-1:0] o_s;
        cic_interpolator #(
            .InputLengthBits  (16),
            .OutputLengthBits (OL),
            .Rate             (R),
            .Order            (N)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in        (din[g]),
            .in_valid  (vin[g]),
            .in_ready  (rin[g]),
            .out       (o_s),
            .out_valid (vout[g]),
            .out_ready (ordy[g])
        );
        assign dout[g] = 22'($signed(o_s));
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            acc  [NI][0:2047];
    int            nacc [NI];
    int            nout [NI];
    longint        hc   [NI][0:63];
    longint        cap  [NI][0:63];
    int            ncap [NI];
    logic [NI-1:0] stall_prev;
    logic [NI-1:0] accepted;
    logic [21:0]   prev_out [NI];
    logic          rst_prev;

    longint exp_impulse_n1 [0:7] = '{1, 1, 1, 1, 0, 0, 0, 0};
    longint exp_triangle   [0:5] = '{1, 2, 1, 0, 0, 0};

    task automatic chk(input string nm, input int g, input longint act, input longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, g, act, want, $time);
        end
    endtask

    function automatic longint sval(input int g);
        return longint'($signed(dout[g]));
    endfunction

    // Impulse response of each instance: boxcar of length R convolved N times.
    task automatic build_h();
        longint a [0:63];
        longint b [0:63];
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < 64; k++) a[k] = 0;
            a[0] = 1;
            for (int s = 0; s < order_of(g); s++) begin
                for (int k = 0; k < 64; k++) begin
                    b[k] = 0;
                    for (int j = 0; j < rate_of(g); j++) begin
                        if (k - j >= 0) b[k] += a[k-j];
                    end
                end
                for (int k = 0; k < 64; k++) a[k] = b[k];
            end
            for (int k = 0; k < 64; k++) hc[g][k] = a[k];
        end
    endtask

    // Exact (unbounded) output sample n of instance g.
    function automatic longint exp_y(input int g, input int n);
        longint s = 0;
        int     r = rate_of(g);
        for (int m = n / r; m >= 0 && (n - m * r) < 64; m--) begin
            if (m < nacc[g]) s += longint'(acc[g][m]) * hc[g][n - m * r];
        end
        return s;
    endfunction

    // Wrap to W bits, then reduce to the output width.
    function automatic longint scale_model(input int w, input int ol, input longint y);
        longint m;
        longint q;
        m = y & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
        if (ol >= w) return m;
`ifdef CIC_INTERPOLATOR_ROUND_EN
        q = (m + (longint'(1) << (w - ol - 1))) >>> (w - ol);
        if (q > (longint'(1) << (ol - 1)) - 1) q = (longint'(1) << (ol - 1)) - 1;
        if (q < -(longint'(1) << (ol - 1)))    q = -(longint'(1) << (ol - 1));
`else
        q = m >>> (w - ol);
`endif
        return q;
    endfunction

    // Per-cycle comparison of every instance against the model (at negedge).
    task automatic cmp_cycle();
        longint e;
        logic   exp_rdy;
        int     r;
        for (int g = 0; g < NI; g++) begin
            r = rate_of(g);
            if (rst_prev) begin
                chk("reset_out", g, sval(g), 0);
                chk("reset_out_valid", g, longint'(vout[g]), 0);
            end
            exp_rdy = !rst && ((nout[g] + int'(vout[g])) == nacc[g] * r) && (!vout[g] || ordy[g]);
            chk("in_ready", g, longint'(rin[g]), longint'(exp_rdy));
            if (stall_prev[g]) begin
                chk("hold_valid", g, longint'(vout[g]), 1);
                chk("hold_out", g, sval(g), longint'($signed(prev_out[g])));
            end
            if (!rst && vout[g] && ordy[g]) begin
                e = scale_model(width_of(g), olen_of(g), exp_y(g, nout[g]));
                chk("out", g, sval(g), e);
                if (ncap[g] < 64) begin
                    cap[g][ncap[g]] = sval(g);
                    ncap[g]++;
                end
                nout[g]++;
            end
            stall_prev[g] = !rst && vout[g] && !ordy[g];
            prev_out[g]   = dout[g];
            accepted[g]   = !rst && vin[g] && rin[g];
            if (accepted[g] && nacc[g] < 2048) begin
                acc[g][nacc[g]] = int'($signed(din[g]));
                nacc[g]++;
            end
            if (rst) begin
                nacc[g] = 0;
                nout[g] = 0;
            end
        end
        rst_prev = rst;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input int val);
        int t;
        t      = 0;
        din[g] = 16'(val);
        vin[g] = 1'b1;
        do begin
            tick();
            t++;
        end while (!accepted[g] && t < 100);
        chk("send_accepted", g, longint'(accepted[g]), 1);
        vin[g] = 1'b0;
    endtask

    task automatic run_const(input int g, input int val, input int count, output int gaps);
        int t;
        int na;
        t      = 0;
        na     = 0;
        gaps   = 0;
        din[g] = 16'(val);
        vin[g] = 1'b1;
        while (na < count && t < 1000) begin
            tick();
            t++;
            if (accepted[g]) na++;
            if (na > 0 && !vout[g]) gaps++;
        end
        chk("const_accept_count", g, na, count);
        vin[g] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gaps;
        int stall_acc;
        rst        = 1'b1;
        vin        = '0;
        ordy       = '1;
        stall_prev = '0;
        accepted   = '0;
        rst_prev   = 1'b0;
        for (int g = 0; g < NI; g++) begin
            din[g]  = '0;
            nacc[g] = 0;
            nout[g] = 0;
            ncap[g] = 0;
        end
        build_h();

        // Hand-computed pins on the model itself.
        chk("pin_tri_h0", 1, hc[1][0], 1);
        chk("pin_tri_h1", 1, hc[1][1], 2);
        chk("pin_tri_h2", 1, hc[1][2], 1);
        chk("pin_tri_h3", 1, hc[1][3], 0);
        chk("pin_dc_48", 2, 3 * (hc[2][1] + hc[2][5] + hc[2][9]), 48);
        chk("pin_wrap18", 0, scale_model(18, 22, 131072), -131072);
        chk("pin_scale_neg", 3, scale_model(22, 12, -524288), -512);
        chk("pin_scale_sat", 3, scale_model(22, 12, 2097151), 2047);
`ifdef CIC_INTERPOLATOR_ROUND_EN
        chk("pin_scale_round", 3, scale_model(22, 12, 1536), 2);
`else
        chk("pin_scale_round", 3, scale_model(22, 12, 1536), 1);
`endif

        repeat (3) tick();
        rst = 1'b0;

        // R=4, N=1 impulse.
        ncap[0] = 0;
        send(0, 1);
        send(0, 0);
        repeat (10) tick();
        chk("t1_count", 0, longint'(ncap[0] >= 8), 1);
        for (int i = 0; i < 8; i++) chk("t1_impulse", 0, cap[0][i], exp_impulse_n1[i]);

        // R=2, N=2 triangle.
        ncap[1] = 0;
        send(1, 1);
        send(1, 0);
        send(1, 0);
        repeat (8) tick();
        chk("t2_count", 1, longint'(ncap[1] >= 6), 1);
        for (int i = 0; i < 6; i++) chk("t2_triangle", 1, cap[1][i], exp_triangle[i]);

        // R=4, N=3 constant 3 settles at 48, continuous output.
        ncap[2] = 0;
        run_const(2, 3, 8, gaps);
        repeat (6) tick();
        chk("t3_no_gaps", 2, gaps, 0);
        chk("t3_count", 2, longint'(ncap[2] >= 32), 1);
        chk("t3_settle_20", 2, cap[2][20], 48);
        chk("t3_settle_31", 2, cap[2][31], 48);

        // Max-negative input, full width and reduced width.
        ncap[2] = 0;
        run_const(2, -32768, 8, gaps);
        repeat (6) tick();
        chk("t6_full", 2, cap[2][31], -524288);
        ncap[3] = 0;
        run_const(3, -32768, 8, gaps);
        repeat (6) tick();
        chk("t6_narrow", 3, cap[3][31], -512);

        // Backpressure mid-burst on the R=4, N=3 instance.
        stall_acc = 0;
        vin[2]    = 1'b1;
        din[2]    = 16'($urandom);
        for (int c = 0; c < 40; c++) begin
            ordy[2] = !(c >= 15 && c < 20);
            tick();
            if (c >= 15 && c < 20 && accepted[2]) stall_acc++;
            if (accepted[2]) din[2] = 16'($urandom);
        end
        vin[2]  = 1'b0;
        ordy[2] = 1'b1;
        chk("t4_no_accept_in_stall", 2, stall_acc, 0);

        // Randomized traffic on all instances.
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < NI; g++) begin
                vin[g]  = ($urandom_range(0, 3) != 0);
                din[g]  = 16'($urandom);
                ordy[g] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        vin  = '0;
        ordy = '1;
        repeat (40) tick();

        // Reset during the zero-stuff phase, then a clean impulse response.
        send(0, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_in_ready", 0, longint'(rin[0]), 1);
        ncap[0] = 0;
        send(0, 1);
        send(0, 0);
        repeat (10) tick();
        chk("t5_count", 0, longint'(ncap[0] >= 8), 1);
        for (int i = 0; i < 8; i++) chk("t5_impulse", 0, cap[0][i], exp_impulse_n1[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
